// File: rtl/demux_fifo4_if.sv
// rtl/demux_fifo4_if.sv - word input, per-lane pop/head/status and drop counter bundle
interface demux_fifo4_if;
    logic [11:0] data_in;
    logic        pop0;
    logic        pop1;
    logic        pop2;
    logic        pop3;
    logic [11:0] data_out0;
    logic [11:0] data_out1;
    logic [11:0] data_out2;
    logic [11:0] data_out3;
    logic        empty0;
    logic        empty1;
    logic        empty2;
    logic        empty3;
    logic        full0;
    logic        full1;
    logic        full2;
    logic        full3;
    logic        almost_full0;
    logic        almost_full1;
    logic        almost_full2;
    logic        almost_full3;
    logic [7:0]  drop_count;

    modport master (
        output data_in, pop0, pop1, pop2, pop3,
        input  data_out0, data_out1, data_out2, data_out3,
        input  empty0, empty1, empty2, empty3,
        input  full0, full1, full2, full3,
        input  almost_full0, almost_full1, almost_full2, almost_full3,
        input  drop_count
    );

    modport slave (
        input  data_in, pop0, pop1, pop2, pop3,
        output data_out0, data_out1, data_out2, data_out3,
        output empty0, empty1, empty2, empty3,
        output full0, full1, full2, full3,
        output almost_full0, almost_full1, almost_full2, almost_full3,
        output drop_count
    );
endinterface

// File: rtl/demux_fifo4.sv
// rtl/demux_fifo4.sv - tag-routed demux into four show-ahead lane FIFOs with drop counter
module demux_fifo4 #(
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3
) (
    input logic          clk,
    input logic          reset_L,
    demux_fifo4_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [11:0]   mem [4][DEPTH];
    logic [PW-1:0] wr_ptr [4];
    logic [PW-1:0] rd_ptr [4];
    logic [CW-1:0] count [4];
    logic [7:0]    drop_count;

    logic [3:0]    pop;
    logic [3:0]    push;
    logic [3:0]    pop_ok;
    logic [3:0]    wr_ok;
    logic [3:0]    drop;
    logic [1:0]    lane;
    logic          push_any;

    logic [11:0]   dout [4];
    logic [3:0]    empty;
    logic [3:0]    full;
    logic [3:0]    almost_full;

    assign pop      = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
    assign lane     = bus.data_in[11:10];
    assign push_any = (bus.data_in != 12'h000);

    // A full lane still accepts a push when its own pop frees the head slot in the same cycle.
    always_comb begin
        push   = '0;
        pop_ok = '0;
        wr_ok  = '0;
        drop   = '0;
        for (int i = 0; i < 4; i++) begin
            push[i]   = push_any && (lane == 2'(i));
            pop_ok[i] = pop[i] && (count[i] != '0);
            wr_ok[i]  = push[i] && ((count[i] != CW'(DEPTH)) || pop_ok[i]);
            drop[i]   = push[i] && !wr_ok[i];
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            drop_count <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_ok[i])
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop_ok[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                case ({wr_ok[i], pop_ok[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
            if ((|drop) && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end

    // Storage is never cleared; a zero count hides stale entries after reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_ok[i])
                mem[i][wr_ptr[i]] <= bus.data_in;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty[i]       = (count[i] == '0);
            full[i]        = (count[i] == CW'(DEPTH));
            almost_full[i] = (32'(count[i]) >= AF_LEVEL);
            dout[i]        = empty[i] ? 12'h000 : mem[i][rd_ptr[i]];
        end
    end

    assign bus.data_out0    = dout[0];
    assign bus.data_out1    = dout[1];
    assign bus.data_out2    = dout[2];
    assign bus.data_out3    = dout[3];
    assign bus.empty0       = empty[0];
    assign bus.empty1       = empty[1];
    assign bus.empty2       = empty[2];
    assign bus.empty3       = empty[3];
    assign bus.full0        = full[0];
    assign bus.full1        = full[1];
    assign bus.full2        = full[2];
    assign bus.full3        = full[3];
    assign bus.almost_full0 = almost_full[0];
    assign bus.almost_full1 = almost_full[1];
    assign bus.almost_full2 = almost_full[2];
    assign bus.almost_full3 = almost_full[3];
    assign bus.drop_count   = drop_count;
endmodule
